iob_uart_csr_responder: RTL and testbench
=========================================

// Module: iob_uart_csr_responder
// PURPOSE
//  IOb-native subordinate that answers the UART CSR accesses issued by a bus initiator (CPU or bench).
//  It holds the UART CSR bank plus TX/RX byte FIFOs and hands bytes to/from an external serializer over valid/ready streams.
//  It sits between the system interconnect and the UART bit engine.
// PARAMETERS
//  DATA_W      32  bus data width (fixed 32; wstrb is 4 bits)
//  ADDR_W      5   byte address width of the CSR window
//  FIFO_LOG2   2   log2 depth of each byte FIFO (depth 4 by default)
// PORTS
//  clk_i          in   1       clock
//  cke_i          in   1       clock enable; when 0 all state holds
//  arst_i         in   1       asynchronous reset, active-low
//  iob_valid_i    in   1       request valid
//  iob_addr_i     in   ADDR_W  byte address
//  iob_wdata_i    in   DATA_W  write data
//  iob_wstrb_i    in   4       byte strobes; all-zero = read
//  iob_rdata_o    out  DATA_W  read data, valid with iob_rvalid_o
//  iob_ready_o    out  1       request accepted this cycle
//  iob_rvalid_o   out  1       read data valid
//  div_o          out  16      baud divider to bit engine
//  tx_data_o      out  8       byte to serializer
//  tx_valid_o     out  1       TX byte valid
//  tx_ready_i     in   1       serializer takes byte
//  rx_data_i      in   8       byte from deserializer
//  rx_valid_i     in   1       RX byte valid
//  rx_ready_o     out  1       responder accepts RX byte
// BEHAVIOUR
//  Reset (arst_i=0): iob_ready_o=0 during reset, rdata=0, rvalid=0, div_o=0, TXEN=RXEN=0, SOFTRESET=0, both FIFOs empty.
//  Map (word aligned, addr[1:0] ignored): 0x00 SOFTRESET W1; 0x04 DIV RW16; 0x08 TXDATA W8; 0x0C RXDATA R8;
//   0x10 TXEN RW1; 0x14 RXEN RW1; 0x18 TXREADY R1; 0x1C RXREADY R1. Unmapped: writes ignored, reads return 0.
//  Handshake: request accepted when iob_valid_i & iob_ready_o. iob_ready_o=1 out of reset except:
//   TXDATA write while TX FIFO full -> iob_ready_o=0 (initiator holds request until space).
//  Writes: take effect on the accepting edge; no rvalid. DIV uses lanes 0-1; 1-bit/8-bit CSRs use lane 0 only.
//  Reads: rdata registered, iob_rvalid_o pulses exactly 1 cycle after acceptance; back-to-back reads allowed every cycle.
//  Bus FSM: IDLE -> RDATA (read accepted) -> IDLE or RDATA again if another read accepted in that cycle.
//  TXREADY = TXEN & !tx_full; RXREADY = RXEN & !rx_empty (zero-extended).
//  RXDATA read pops RX FIFO when non-empty; when empty returns 0, no pop, no underflow.
//  tx_valid_o = TXEN & !tx_empty; pop on tx_valid_o & tx_ready_i. Push on accepted TXDATA write; push+pop same cycle legal.
//  rx_ready_o = RXEN & !rx_full (not relaxed by a same-cycle pop); push on rx_valid_i & rx_ready_o.
//  SOFTRESET=1: both FIFOs held empty, tx_valid_o=0, rx_ready_o=0, TXDATA writes accepted and dropped; DIV/TXEN/RXEN kept.
//  FIFO pointers FIFO_LOG2+1 bits, wrap modulo 2*depth; full = MSBs differ & LSBs equal.
//  Async reset mid-transfer aborts it; a pending rvalid is dropped.
// STRUCTURE
//  Package iob_uart_csr_pkg: CSR address localparams, CSR widths, reset values.
//  Sub-module iob_uart_byte_fifo (sync FIFO, 8-bit, depth 2**FIFO_LOG2, push/pop/full/empty/level), instanced twice.
//  Top: address decode, CSR regs, bus FSM, ready/rvalid generation.
// TESTING
//  Init: write SOFTRESET=1, SOFTRESET=0, DIV=0x01B2, RXEN=1, TXEN=1; read DIV -> 0x000001B2, rvalid 1 cycle after accept.
//  TX: tx_ready_i=0, write TXDATA 0x41..0x44 -> 4 accepted, TXREADY reads 0, 5th write sees iob_ready_o=0;
//   raise tx_ready_i -> tx_data_o emits 0x41,0x42,0x43,0x44 in order, stalled write then completes, 0x45 follows.
//  RX: drive rx bytes 0x55,0xAA -> RXREADY=1; read RXDATA twice -> 0x55, 0xAA; third read -> 0, RXREADY=0.
//  RX full: 5 bytes offered with no reads -> rx_ready_o low after 4th; reads return first 4 bytes only.
//  SOFTRESET with 2 bytes in each FIFO -> tx_valid_o=0, RXREADY=0; clear -> FIFOs empty, DIV still 0x01B2.
//  Reset mid-read: assert arst_i low the cycle after a read accept -> no rvalid, all outputs at reset values.

Source files
------------

// File: rtl/iob_uart_csr_pkg.sv
// UART CSR responder shared definitions.
// Holds the word-index CSR map, CSR widths, CSR reset values and the
// bus-side FSM state type.
package iob_uart_csr_pkg;

  localparam int unsigned CSR_SEL_W = 3;
  localparam int unsigned DIV_W     = 16;
  localparam int unsigned BYTE_W    = 8;

  // Word index of each CSR (byte address bits [4:2]).
  localparam logic [CSR_SEL_W-1:0] CSR_SOFTRESET = 3'd0;
  localparam logic [CSR_SEL_W-1:0] CSR_DIV       = 3'd1;
  localparam logic [CSR_SEL_W-1:0] CSR_TXDATA    = 3'd2;
  localparam logic [CSR_SEL_W-1:0] CSR_RXDATA    = 3'd3;
  localparam logic [CSR_SEL_W-1:0] CSR_TXEN      = 3'd4;
  localparam logic [CSR_SEL_W-1:0] CSR_RXEN      = 3'd5;
  localparam logic [CSR_SEL_W-1:0] CSR_TXREADY   = 3'd6;
  localparam logic [CSR_SEL_W-1:0] CSR_RXREADY   = 3'd7;

  localparam logic [DIV_W-1:0] DIV_RST       = '0;
  localparam logic             TXEN_RST      = 1'b0;
  localparam logic             RXEN_RST      = 1'b0;
  localparam logic             SOFTRESET_RST = 1'b0;

  typedef enum logic {
    BUS_IDLE,
    BUS_RDATA
  } bus_state_t;

endpackage

// File: rtl/iob_uart_csr_responder_fifo.sv
// iob_uart_byte_fifo: synchronous 8-bit FIFO, depth 2**FIFO_LOG2, first-word
// fall-through read port.
// Ports: clk_i/cke_i/arst_i (clock, enable, async active-low reset),
// clr_i (hold empty), push_i/din_i, pop_i/dout_o, full_o, empty_o, level_o.
// Pushes while full and pops while empty are ignored.
module iob_uart_byte_fifo
  import iob_uart_csr_pkg::*;
#(
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic [BYTE_W-1:0]   din_i,
  input  logic                pop_i,
  output logic [BYTE_W-1:0]   dout_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [FIFO_LOG2:0]  level_o
);

  localparam int unsigned DEPTH = 2 ** FIFO_LOG2;

  logic [BYTE_W-1:0]  mem [DEPTH];
  logic [FIFO_LOG2:0] wptr, rptr;
  logic               do_push, do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full_o  = (wptr[FIFO_LOG2] != rptr[FIFO_LOG2]) &&
                   (wptr[FIFO_LOG2-1:0] == rptr[FIFO_LOG2-1:0]);
  assign empty_o = (wptr == rptr);
  assign level_o = wptr - rptr;
  assign dout_o  = mem[rptr[FIFO_LOG2-1:0]];

  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (cke_i) begin
      if (clr_i) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (do_pop)  rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && do_push) mem[wptr[FIFO_LOG2-1:0]] <= din_i;
  end

endmodule

// File: rtl/iob_uart_csr_responder.sv
// iob_uart_csr_responder: IOb subordinate holding the UART CSR bank and the
// TX/RX byte FIFOs between the interconnect and the UART bit engine.
// Ports: clk_i/cke_i/arst_i (clock, enable, async active-low reset);
// iob_* request/response channel; div_o baud divider; tx_* byte stream to
// the serializer; rx_* byte stream from the deserializer.
module iob_uart_csr_responder
  import iob_uart_csr_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              iob_valid_i,
  input  logic [ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W-1:0] iob_wdata_i,
  input  logic [3:0]        iob_wstrb_i,
  output logic [DATA_W-1:0] iob_rdata_o,
  output logic              iob_ready_o,
  output logic              iob_rvalid_o,
  output logic [DIV_W-1:0]  div_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o
);

  localparam logic [FIFO_LOG2:0] FIFO_DEPTH = (FIFO_LOG2 + 1)'(2 ** FIFO_LOG2);

  bus_state_t             state_q, state_d;
  logic                   rdy_en;
  logic [DIV_W-1:0]       div_q;
  logic                   txen_q, rxen_q, srst_q;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [CSR_SEL_W-1:0]   sel;
  logic                   hit, acc, wr, rd;
  logic                   tx_push_req, tx_push, tx_pop, rx_push, rx_pop, rx_avail;
  logic                   tx_full, tx_empty, rx_full, rx_empty;
  logic [FIFO_LOG2:0]     tx_level, rx_level;
  logic [BYTE_W-1:0]      rx_dout;
  logic                   unused_wdata_hi;

  assign unused_wdata_hi = ^iob_wdata_i[DATA_W-1:DIV_W];

  assign sel = iob_addr_i[4:2];
  assign hit = ((iob_addr_i >> 5) == '0);

  // A TXDATA write that would really push must wait for space; dropped
  // writes under SOFTRESET never stall.
  assign tx_push_req = hit & (sel == CSR_TXDATA) & iob_wstrb_i[0] & ~srst_q;
  assign iob_ready_o = rdy_en & cke_i & ~(iob_valid_i & tx_push_req & tx_full);

  assign acc     = iob_valid_i & iob_ready_o;
  assign wr      = acc & (|iob_wstrb_i);
  assign rd      = acc & ~(|iob_wstrb_i);
  assign tx_push = wr & tx_push_req;

  // SOFTRESET gates the FIFO-facing outputs at once; the FIFOs are cleared
  // on the following edge.
  assign tx_valid_o = txen_q & ~tx_empty & ~srst_q;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign rx_ready_o = rxen_q & ~rx_full & ~srst_q;
  assign rx_push    = rx_valid_i & rx_ready_o;
  assign rx_avail   = ~rx_empty & ~srst_q;
  assign rx_pop     = rd & hit & (sel == CSR_RXDATA) & rx_avail;

  assign div_o       = div_q;
  assign iob_rdata_o = rdata_q;

  iob_uart_byte_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_i  (arst_i),
    .clr_i   (srst_q),
    .push_i  (tx_push),
    .din_i   (iob_wdata_i[BYTE_W-1:0]),
    .pop_i   (tx_pop),
    .dout_o  (tx_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  iob_uart_byte_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_i  (arst_i),
    .clr_i   (srst_q),
    .push_i  (rx_push),
    .din_i   (rx_data_i),
    .pop_i   (rx_pop),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  always_comb begin
    rdata_d = '0;
    if (hit) begin
      case (sel)
        CSR_DIV:     rdata_d[DIV_W-1:0]  = div_q;
        CSR_RXDATA:  if (rx_avail) rdata_d[BYTE_W-1:0] = rx_dout;
        CSR_TXEN:    rdata_d[0] = txen_q;
        CSR_RXEN:    rdata_d[0] = rxen_q;
        CSR_TXREADY: rdata_d[0] = txen_q & (srst_q | (tx_level != FIFO_DEPTH));
        CSR_RXREADY: rdata_d[0] = rxen_q & ~srst_q & (rx_level != '0);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d      = BUS_IDLE;
    iob_rvalid_o = 1'b0;
    case (state_q)
      BUS_IDLE:  if (rd) state_d = BUS_RDATA;
      BUS_RDATA: begin
        iob_rvalid_o = 1'b1;
        if (rd) state_d = BUS_RDATA;
      end
      default:   state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= BUS_IDLE;
      rdy_en  <= 1'b0;
      rdata_q <= '0;
      div_q   <= DIV_RST;
      txen_q  <= TXEN_RST;
      rxen_q  <= RXEN_RST;
      srst_q  <= SOFTRESET_RST;
    end else if (cke_i) begin
      state_q <= state_d;
      rdy_en  <= 1'b1;
      if (rd) rdata_q <= rdata_d;
      if (wr && hit) begin
        case (sel)
          CSR_SOFTRESET: if (iob_wstrb_i[0]) srst_q <= iob_wdata_i[0];
          CSR_DIV: begin
            if (iob_wstrb_i[0]) div_q[7:0]  <= iob_wdata_i[7:0];
            if (iob_wstrb_i[1]) div_q[15:8] <= iob_wdata_i[15:8];
          end
          CSR_TXEN:      if (iob_wstrb_i[0]) txen_q <= iob_wdata_i[0];
          CSR_RXEN:      if (iob_wstrb_i[0]) rxen_q <= iob_wdata_i[0];
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iob_uart_csr_responder.sv
`timescale 1ns/1ps
module tb_iob_uart_csr_responder;

  logic        clk = 1'b0;
  logic        cke;
  logic        arst_n;
  logic        iob_valid;
  logic [4:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic [31:0] iob_rdata;
  logic        iob_ready;
  logic        iob_rvalid;
  logic [15:0] div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int unsigned n_asrt = 0;
  int unsigned n_fail = 0;
  int unsigned tx_count = 0;

  // Reference model state
  logic [15:0] m_div;
  bit          m_txen, m_rxen, m_srst;
  logic [7:0]  m_txq [$];
  logic [7:0]  m_rxq [$];

  localparam logic [4:0] A_SRST = 5'h00, A_DIV = 5'h04, A_TXD = 5'h08, A_RXD = 5'h0C,
                         A_TXEN = 5'h10, A_RXEN = 5'h14, A_TXRDY = 5'h18, A_RXRDY = 5'h1C;

  iob_uart_csr_responder #(.DATA_W(32), .ADDR_W(5), .FIFO_LOG2(2)) dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .arst_i       (arst_n),
    .iob_valid_i  (iob_valid),
    .iob_addr_i   (iob_addr),
    .iob_wdata_i  (iob_wdata),
    .iob_wstrb_i  (iob_wstrb),
    .iob_rdata_o  (iob_rdata),
    .iob_ready_o  (iob_ready),
    .iob_rvalid_o (iob_rvalid),
    .div_o        (div),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serializer side: every negedge, tx_valid must match the model; each
  // handshake must carry the oldest queued byte.
  always @(negedge clk) begin
    if (arst_n === 1'b1) begin
      chk("tx_valid", tx_valid, (m_txen && !m_srst && m_txq.size() > 0));
      if (tx_valid && tx_ready && m_txq.size() > 0) begin
        chk("tx_data", tx_data, m_txq.pop_front());
        tx_count++;
      end
    end
  end

  task automatic model_reset();
    m_div = 16'h0; m_txen = 0; m_rxen = 0; m_srst = 0;
    m_txq.delete(); m_rxq.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic bus_req(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int unsigned release_after);
    bit ok = 0;
    iob_valid = 1'b1; iob_addr = a; iob_wdata = d; iob_wstrb = s;
    for (int unsigned n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (iob_ready === 1'b1) ok = 1;
      else begin
        @(posedge clk); #1;
        if (release_after != 0 && n + 1 >= release_after) tx_ready = 1'b1;
      end
    end
    chk("accept_timeout", ok, 1);
    if (ok) begin @(posedge clk); #1; end
    iob_valid = 1'b0; iob_wstrb = 4'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int unsigned rel);
    bus_req(a, d, s, rel);
    case (a[4:2])
      3'd0: if (s[0]) begin
        m_srst = d[0];
        if (m_srst) begin m_txq.delete(); m_rxq.delete(); end
      end
      3'd1: begin
        if (s[0]) m_div[7:0]  = d[7:0];
        if (s[1]) m_div[15:8] = d[15:8];
      end
      3'd2: if (s[0] && !m_srst) m_txq.push_back(d[7:0]);
      3'd4: if (s[0]) m_txen = d[0];
      3'd5: if (s[0]) m_rxen = d[0];
      default: ;
    endcase
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a);
    logic [31:0] exp;
    case (a[4:2])
      3'd1: exp = {16'h0, m_div};
      3'd3: exp = (!m_srst && m_rxq.size() > 0) ? {24'h0, m_rxq.pop_front()} : 32'h0;
      3'd4: exp = {31'h0, m_txen};
      3'd5: exp = {31'h0, m_rxen};
      3'd6: exp = {31'h0, m_txen && m_txq.size() < 4};
      3'd7: exp = {31'h0, m_rxen && !m_srst && m_rxq.size() > 0};
      default: exp = 32'h0;
    endcase
    bus_req(a, 32'h0, 4'h0, 0);
    chk({tag, "_rvalid"}, iob_rvalid, 1);
    chk(tag, iob_rdata, exp);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bit exp_rdy;
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    exp_rdy = m_rxen && !m_srst && m_rxq.size() < 4;
    chk("rx_ready", rx_ready, exp_rdy);
    if (exp_rdy) m_rxq.push_back(b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    cke = 1; arst_n = 0; iob_valid = 0; iob_addr = 0; iob_wdata = 0; iob_wstrb = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", iob_ready, 0);
    chk("rst_rvalid", iob_rvalid, 0);
    chk("rst_rdata", iob_rdata, 0);
    chk("rst_div", div, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    @(negedge clk); arst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", iob_ready, 1);

    // Init sequence
    do_write(A_SRST, 32'h1, 4'h1, 0);
    do_write(A_SRST, 32'h0, 4'h1, 0);
    do_write(A_DIV, 32'h0000_01B2, 4'h3, 0);
    do_write(A_RXEN, 32'h1, 4'h1, 0);
    do_write(A_TXEN, 32'h1, 4'h1, 0);
    chk("div_o", div, 16'h01B2);
    rd_chk("div_read", A_DIV);
    @(posedge clk); #1;
    chk("rvalid_one_cycle", iob_rvalid, 0);

    // TX: fill, stall, drain in order
    tx_ready = 0;
    for (int i = 0; i < 4; i++) do_write(A_TXD, 32'h41 + i, 4'h1, 0);
    rd_chk("txready_full", A_TXRDY);
    iob_valid = 1; iob_addr = A_TXD; iob_wdata = 32'h45; iob_wstrb = 4'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tx_full_stall", iob_ready, 0);
      @(posedge clk); #1;
    end
    tx_ready = 1;
    do_write(A_TXD, 32'h45, 4'h1, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("tx_drained", m_txq.size(), 0);
    chk("tx_count", tx_count, 5);

    // RX basic
    send_rx(8'h55);
    send_rx(8'hAA);
    rd_chk("rxready_1", A_RXRDY);
    rd_chk("rxdata_55", A_RXD);
    rd_chk("rxdata_AA", A_RXD);
    rd_chk("rxdata_empty", A_RXD);
    rd_chk("rxready_0", A_RXRDY);

    // RX full: fifth byte refused
    for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) rd_chk("rx_full_read", A_RXD);

    // SOFTRESET with data in both FIFOs
    tx_ready = 0;
    do_write(A_TXD, 32'hC1, 4'h1, 0);
    do_write(A_TXD, 32'hC2, 4'h1, 0);
    send_rx(8'h31);
    send_rx(8'h32);
    do_write(A_SRST, 32'h1, 4'h1, 0);
    @(negedge clk);
    chk("srst_rx_ready", rx_ready, 0);
    @(posedge clk); #1;
    rd_chk("srst_rxready", A_RXRDY);
    do_write(A_TXD, 32'h99, 4'h1, 0);
    do_write(A_SRST, 32'h0, 4'h1, 0);
    rd_chk("post_srst_txready", A_TXRDY);
    rd_chk("post_srst_rxready", A_RXRDY);
    rd_chk("post_srst_div", A_DIV);
    tx_ready = 1;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          tx_ready = 1'($urandom_range(0, 1));
          do_write(A_TXD, $urandom, 4'h1, tx_ready ? 0 : 6);
        end
        1: send_rx(8'($urandom));
        2: rd_chk("rnd_rxdata", A_RXD | 5'($urandom_range(0, 3)));
        3: do_write(A_DIV, $urandom, 4'($urandom_range(1, 15)), 0);
        4: case ($urandom_range(0, 3))
             0: rd_chk("rnd_div", A_DIV | 5'($urandom_range(0, 3)));
             1: rd_chk("rnd_txready", A_TXRDY);
             2: rd_chk("rnd_rxready", A_RXRDY);
             default: rd_chk("rnd_txdata_rd", A_TXD);
           endcase
        default: begin
          tx_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      endcase
    end
    tx_ready = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("rnd_tx_drained", m_txq.size(), 0);
    chk("rnd_div_o", div, m_div);

    // Async reset the cycle after a read is accepted
    iob_valid = 1; iob_addr = A_DIV; iob_wstrb = 4'h0;
    @(negedge clk);
    chk("midrd_ready", iob_ready, 1);
    @(posedge clk); #1;
    arst_n = 0; iob_valid = 0;
    model_reset();
    #1;
    chk("midrd_rvalid", iob_rvalid, 0);
    chk("midrd_ready_rst", iob_ready, 0);
    chk("midrd_rdata", iob_rdata, 0);
    chk("midrd_div", div, 0);
    chk("midrd_tx_valid", tx_valid, 0);
    chk("midrd_rx_ready", rx_ready, 0);
    @(negedge clk); arst_n = 1;
    @(posedge clk); #1;
    chk("midrd_rvalid_after", iob_rvalid, 0);
    rd_chk("post_rst_div", A_DIV);
    rd_chk("post_rst_txen", A_TXEN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
